// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with synchronous clear/load, programmable terminal value,
// a terminal-count pulse and a sticky overflow flag. All outputs are registered.
// Optional build macro COUNTER_SAT_EN: saturate at the bounds instead of wrapping.
module counter_updown_mod #(
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned CNT_MAX       = (2 ** COUNTER_WIDTH) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up_dn,
  input  logic                     clr,
  input  logic                     ld,
  input  logic [COUNTER_WIDTH-1:0] ld_val,
  output logic [COUNTER_WIDTH-1:0] cntr_o,
  output logic                     tc_o,
  output logic                     zero_o,
  output logic                     ovf_o
);

  localparam logic [COUNTER_WIDTH-1:0] MaxVal = CNT_MAX[COUNTER_WIDTH-1:0];

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     tc_q, tc_d;
  logic                     zero_q, zero_d;
  logic                     ovf_q, ovf_d;

  // One extra bit so the increment of 2**W-1 is visible as a crossing.
  logic [COUNTER_WIDTH:0]   inc_w;
  logic [COUNTER_WIDTH-1:0] dec_w;
  logic                     at_max_w;
  logic                     at_zero_w;

  assign inc_w     = {1'b0, cnt_q} + 1'b1;
  assign dec_w     = cnt_q - 1'b1;
  assign at_max_w  = (inc_w > {1'b0, MaxVal});
  assign at_zero_w = (cnt_q == '0);

  // Next-state: clr beats ld beats en; tc is only raised on a boundary event.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (ld) begin
      cnt_d = (ld_val > MaxVal) ? MaxVal : ld_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max_w) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`ifdef COUNTER_SAT_EN
          cnt_d = MaxVal;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = inc_w[COUNTER_WIDTH-1:0];
        end
      end else begin
        if (at_zero_w) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`ifdef COUNTER_SAT_EN
          cnt_d = '0;
`else
          cnt_d = MaxVal;
`endif
        end else begin
          cnt_d = dec_w;
        end
      end
    end
    // Derived from the next value so zero_o never lags cntr_o.
    zero_d = (cnt_d == '0);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cntr_o = cnt_q;
  assign tc_o   = tc_q;
  assign zero_o = zero_q;
  assign ovf_o  = ovf_q;

endmodule
